shift_sub_divider: RTL

- Sequential restoring (shift-subtract) divider; the inverse datapath of the team's shift-add multiplier.
- Computes one quotient bit per clock and reuses the same down-counting bit-counter scheme: load N, decrement, finish at zero.
- Sits beside the multiplier under a start/busy/done handshake driven by the system controller.

---
 rtl/shift_sub_divider.sv | 133 +++++++++++++
 1 files changed

// File: rtl/shift_sub_divider.sv
// Sequential restoring shift-subtract divider, one quotient bit per clock, start/busy/done handshake.
// Optional two's-complement operation is enabled by defining SHIFT_SUB_DIVIDER_SIGNED_EN.
module shift_sub_divider #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [N:0]    r;
  logic [N-1:0]  q;
  logic [N-1:0]  dvsr;
  logic [CW-1:0] cnt;

  logic [N:0]    rs;
  logic [N+1:0]  t;
  logic [N:0]    r_nx;
  logic [N-1:0]  q_nx;
  logic [N-1:0]  a_ld;
  logic [N-1:0]  b_ld;
  logic [N-1:0]  quo_fin;
  logic [N-1:0]  rem_fin;

`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
  logic neg_q;
  logic neg_r;
`endif

  always_comb begin
    // {R,Q} shifted left by one; the extra top bit of t is the borrow of the trial subtract
    rs = {r[N-1:0], q[N-1]};
    t  = {1'b0, rs} - {2'b00, dvsr};
    if (!t[N+1]) begin
      r_nx = t[N:0];
      q_nx = {q[N-2:0], 1'b1};
    end else begin
      r_nx = rs;
      q_nx = {q[N-2:0], 1'b0};
    end
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
    a_ld    = dividend[N-1] ? ('0 - dividend) : dividend;
    b_ld    = divisor[N-1]  ? ('0 - divisor)  : divisor;
    quo_fin = neg_q ? ('0 - q_nx) : q_nx;
    rem_fin = neg_r ? ('0 - r_nx[N-1:0]) : r_nx[N-1:0];
`else
    a_ld    = dividend;
    b_ld    = divisor;
    quo_fin = q_nx;
    rem_fin = r_nx[N-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      r           <= '0;
      q           <= '0;
      dvsr        <= '0;
      cnt         <= '0;
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= CALC;
              div_by_zero <= 1'b0;
              r           <= '0;
              q           <= a_ld;
              dvsr        <= b_ld;
              cnt         <= CW'(N);
`ifdef SHIFT_SUB_DIVIDER_SIGNED_EN
              neg_q       <= dividend[N-1] ^ divisor[N-1];
              neg_r       <= dividend[N-1];
`endif
            end
          end
        end
        CALC: begin
          r   <= r_nx;
          q   <= q_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= quo_fin;
            remainder <= rem_fin;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
